// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator and F/D pipeline register (fetch_pc_unit).
// Ports: clk, reset_n; stall, redirect_en/redirect_pc, jb_D, exc_req,
//   eret_req, epc, Instr_F in; PC_F, Instr_D, PC_D, PC8_D, BD_D,
//   ExcCode_D out. Optional macro FETCH_ADEL_CHK_EN enables the AdEL
//   fetch-address check.

package fetch_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
  } if_id_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

endpackage

module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int          IM_WORDS   = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        jb_D,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        BD_D,
  output logic [4:0]  ExcCode_D
);

  localparam logic [31:0] IM_LAST =
    IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

`ifdef FETCH_ADEL_CHK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] pc_seq;
  if_id_t      fd_q;
  if_id_t      fd_next;
  if_id_t      fetched;
  logic        flush;
  logic        addr_bad;

  assign pc_seq = pc_q + 32'd4;
  assign flush  = exc_req | eret_req;

  // Exception beats ERET, both beat stall; a redirect
  // under stall is dropped because D will re-issue it.
  always_comb begin
    pc_next = pc_seq;
    priority case (1'b1)
      exc_req:     pc_next = EXC_VECTOR;
      eret_req:    pc_next = epc;
      stall:       pc_next = pc_q;
      redirect_en: pc_next = redirect_pc;
      default:     pc_next = pc_seq;
    endcase
  end

  // Illegal fetch: misaligned or outside the IM window.
  assign addr_bad = (pc_q[1:0] != 2'b00)
                  | (pc_q < IM_BASE)
                  | (pc_q > IM_LAST);

  always_comb begin
    fetched.instr    = Instr_F;
    fetched.pc       = pc_q;
    fetched.bd       = jb_D;
    fetched.exc_code = EXC_NONE;
    if (CHK_EN && addr_bad) begin
      fetched.instr    = 32'h0;
      fetched.exc_code = EXC_ADEL;
    end
  end

  always_comb begin
    fd_next = fd_q;
    priority case (1'b1)
      flush: begin
        fd_next.instr    = 32'h0;
        fd_next.pc       = pc_q;
        fd_next.bd       = 1'b0;
        fd_next.exc_code = EXC_NONE;
      end
      stall:   fd_next = fd_q;
      default: fd_next = fetched;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fd_q.instr    <= 32'h0;
      fd_q.pc       <= RESET_PC;
      fd_q.bd       <= 1'b0;
      fd_q.exc_code <= EXC_NONE;
    end else begin
      fd_q <= fd_next;
    end
  end

  assign PC_F      = pc_q;
  assign Instr_D   = fd_q.instr;
  assign PC_D      = fd_q.pc;
  assign PC8_D     = fd_q.pc + 32'd8;
  assign BD_D      = fd_q.bd;
  assign ExcCode_D = fd_q.exc_code;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit.
// Vector table feeds a scoreboard queue checked after each edge.

module tb_fetch_pc_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        jb_D;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        BD_D;
  logic [4:0]  ExcCode_D;

  fetch_pc_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .jb_D        (jb_D),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .Instr_F     (Instr_F),
    .PC_F        (PC_F),
    .Instr_D     (Instr_D),
    .PC_D        (PC_D),
    .PC8_D       (PC8_D),
    .BD_D        (BD_D),
    .ExcCode_D   (ExcCode_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_ADEL_CHK_EN
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic        bd;
    logic [4:0]  exc;
  } exp_t;

  typedef struct {
    logic        st;
    logic        re;
    logic [31:0] rpc;
    logic        jb;
    logic        ex;
    logic        er;
    logic [31:0] ep;
    logic [31:0] ins;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] I1  = 32'h2408_0001;
  localparam logic [31:0] I2  = 32'h2409_0002;
  localparam logic [31:0] I3  = 32'h1000_0003;
  localparam logic [31:0] I4  = 32'h240A_0004;
  localparam logic [31:0] I5  = 32'h240B_0005;
  localparam logic [31:0] I6  = 32'h240C_0006;
  localparam logic [31:0] I7  = 32'h240D_0007;
  localparam logic [31:0] I8  = 32'h240E_0008;
  localparam logic [31:0] I9  = 32'h240F_0009;
  localparam logic [31:0] I10 = 32'h2410_000A;
  localparam logic [31:0] I11 = 32'h2411_000B;
  localparam logic [31:0] I12 = 32'h2412_000C;

  function automatic logic [31:0] bad_i(input logic [31:0] i);
    return ADEL ? 32'h0 : i;
  endfunction

  function automatic logic [4:0] bad_e();
    return ADEL ? 5'd4 : 5'd0;
  endfunction

  task automatic add(
    input logic st, input logic re, input logic [31:0] rpc,
    input logic jb, input logic ex, input logic er,
    input logic [31:0] ep, input logic [31:0] ins,
    input logic [31:0] pcf, input logic [31:0] ei,
    input logic [31:0] pcd, input logic bd, input logic [4:0] exc);
    vec_t v;
    v.st = st; v.re = re; v.rpc = rpc; v.jb = jb;
    v.ex = ex; v.er = er; v.ep = ep; v.ins = ins;
    v.e.pcf = pcf; v.e.instr = ei; v.e.pcd = pcd;
    v.e.bd = bd; v.e.exc = exc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, " PC_F"}, PC_F, e.pcf);
    chk({tag, " Instr_D"}, Instr_D, e.instr);
    chk({tag, " PC_D"}, PC_D, e.pcd);
    chk({tag, " PC8_D"}, PC8_D, e.pcd + 32'd8);
    chk({tag, " BD_D"}, 32'(BD_D), 32'(e.bd));
    chk({tag, " ExcCode_D"}, 32'(ExcCode_D), 32'(e.exc));
  endtask

  task automatic idle();
    stall = 0; redirect_en = 0; redirect_pc = 0; jb_D = 0;
    exc_req = 0; eret_req = 0; epc = 0; Instr_F = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // st re rpc jb ex er epc instr | pcf instrD pcD bd exc
    add(0,0,0,0,0,0,0,I1,  32'h3004, I1, 32'h3000, 0, 0);
    add(0,0,0,0,0,0,0,I2,  32'h3008, I2, 32'h3004, 0, 0);
    add(1,0,0,0,0,0,0,I3,  32'h3008, I2, 32'h3004, 0, 0);
    add(1,0,0,0,0,0,0,I3,  32'h3008, I2, 32'h3004, 0, 0);
    add(0,0,0,0,0,0,0,I3,  32'h300C, I3, 32'h3008, 0, 0);
    add(0,1,32'h3100,1,0,0,0,I4,
        32'h3100, I4, 32'h300C, 1, 0);
    add(1,0,0,0,0,0,0,I5,  32'h3100, I4, 32'h300C, 1, 0);
    add(0,0,0,0,0,0,0,I5,  32'h3104, I5, 32'h3100, 0, 0);
    add(1,1,32'h3200,0,0,0,0,I6,
        32'h3104, I5, 32'h3100, 0, 0);
    add(1,0,0,1,1,1,32'h5000,I6,
        32'h4180, 0, 32'h3104, 0, 0);
    add(0,0,0,0,0,0,0,I6,  32'h4184, I6, 32'h4180, 0, 0);
    add(0,0,0,1,0,1,32'h3002,I7,
        32'h3002, 0, 32'h4184, 0, 0);
    add(0,0,0,0,0,0,0,I7,
        32'h3006, bad_i(I7), 32'h3002, 0, bad_e());
    add(0,0,0,0,0,1,32'hFFFF_FFFC,I8,
        32'hFFFF_FFFC, 0, 32'h3006, 0, 0);
    add(0,0,0,0,0,0,0,I8,
        32'h0, bad_i(I8), 32'hFFFF_FFFC, 0, bad_e());
    add(0,0,0,0,0,0,0,I9,
        32'h4, bad_i(I9), 32'h0, 0, bad_e());
    add(0,1,32'h6FFC,0,0,0,0,I10,
        32'h6FFC, bad_i(I10), 32'h4, 0, bad_e());
    add(0,0,0,0,0,0,0,I11, 32'h7000, I11, 32'h6FFC, 0, 0);
    add(0,0,0,0,0,0,0,I12,
        32'h7004, bad_i(I12), 32'h7000, 0, bad_e());

    idle();
    reset_n = 0;
    #12;
    e.pcf = 32'h3000; e.instr = 0; e.pcd = 32'h3000;
    e.bd = 0; e.exc = 0;
    chk_all("reset", e);
    reset_n = 1;

    foreach (vecs[i]) begin
      stall       = vecs[i].st;
      redirect_en = vecs[i].re;
      redirect_pc = vecs[i].rpc;
      jb_D        = vecs[i].jb;
      exc_req     = vecs[i].ex;
      eret_req    = vecs[i].er;
      epc         = vecs[i].ep;
      Instr_F     = vecs[i].ins;
      sb.push_back(vecs[i].e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: queue empty at vec %0d", i);
      end else begin
        e = sb.pop_front();
        chk_all($sformatf("vec%0d", i), e);
      end
    end

    // Asynchronous reset mid-cycle, no edge between assert and check.
    #2;
    reset_n = 0;
    #1;
    e.pcf = 32'h3000; e.instr = 0; e.pcd = 32'h3000;
    e.bd = 0; e.exc = 0;
    chk_all("async_rst", e);
    idle();
    Instr_F = I1;
    #1;
    reset_n = 1;
    @(posedge clk);
    #1;
    e.pcf = 32'h3004; e.instr = I1; e.pcd = 32'h3000;
    chk_all("post_rst", e);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
